// File: rtl/obj_state_bank.sv
// obj_state_bank: x/y/alive bank for NUM_OBJ game objects plus a flag word, a bomb fuse and registered CPU reads.
// Optional macro OBJ_STATE_SHADOW_EN: display ports come from a shadow copy refreshed on frame_sync.
module obj_state_bank #(
    parameter int                NUM_OBJ     = 4,
    parameter int                COORD_W     = 5,
    parameter int                FLAG_W      = 10,
    parameter logic [FLAG_W-1:0] FLAG_INIT   = 10'h030,
    parameter int                BOMB_IDX    = 2,
    parameter int                FUSE_CYCLES = 50000000,
    parameter int                ADDR_W      = $clog2(NUM_OBJ+1)+2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en_i,
    input  logic                       rd_en_i,
    input  logic [ADDR_W-1:0]          addr_i,
    input  logic [31:0]                wdata_i,
    output logic [31:0]                rdata_o,
    output logic                       rd_valid_o,
    input  logic                       frame_sync_i,
    output logic [NUM_OBJ*COORD_W-1:0] disp_x_o,
    output logic [NUM_OBJ*COORD_W-1:0] disp_y_o,
    output logic [NUM_OBJ-1:0]         disp_alive_o,
    output logic [FLAG_W-1:0]          disp_flags_o,
    output logic                       boom_o,
    output logic                       fuse_busy_o
);
    // Fuse FSM
    // state | meaning
    // IDLE  | no bomb armed, count held at 0
    // ARMED | counting down; expiry in the cycle the count is 0
    typedef enum logic {IDLE = 1'b0, ARMED = 1'b1} fuse_state_e;

    localparam int IDX_W       = ADDR_W - 2;
    localparam int OIX_W       = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
    localparam int CNT_W       = $clog2(FUSE_CYCLES);
    localparam int BOMB_EN_BIT = 9;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FUSE_CYCLES - 1);

    logic [NUM_OBJ-1:0][COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic [NUM_OBJ-1:0]              alive_q, alive_d;
    logic [FLAG_W-1:0]               flags_q, flags_d;
    fuse_state_e                     state_q, state_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [31:0]                     rdata_q, rd_word;
    logic                            rd_valid_q;

    logic [IDX_W-1:0] idx;
    logic [OIX_W-1:0] oidx;
    logic [1:0]       fld;
    logic             is_obj, is_glb, bomb_wr, soft_rst, expire;

    assign idx      = addr_i[ADDR_W-1:2];
    assign fld      = addr_i[1:0];
    assign oidx     = idx[OIX_W-1:0];
    assign is_obj   = idx < IDX_W'(NUM_OBJ);
    assign is_glb   = idx == IDX_W'(NUM_OBJ);
    assign bomb_wr  = wr_en_i && (idx == IDX_W'(BOMB_IDX)) && (fld == 2'd2);
    assign soft_rst = wr_en_i && is_glb && (fld == 2'd3);
    // A CPU write to the bomb alive bit (or a soft reset) overrides an expiry in the same cycle.
    assign expire   = (state_q == ARMED) && (cnt_q == '0) && !bomb_wr && !soft_rst;

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        alive_d = alive_q;
        flags_d = flags_q;
        if (wr_en_i && is_obj) begin
            case (fld)
                2'd0:    x_d[oidx] = wdata_i[COORD_W-1:0];
                2'd1:    y_d[oidx] = wdata_i[COORD_W-1:0];
                2'd2:    alive_d[oidx] = wdata_i[0];
                default: begin
                    x_d[oidx] = x_q[0];
                    y_d[oidx] = y_q[0];
                end
            endcase
        end else if (wr_en_i && is_glb) begin
            case (fld)
                2'd0:    flags_d = wdata_i[FLAG_W-1:0];
                2'd1:    flags_d[5:4] = wdata_i[1:0];
                default: ;
            endcase
        end
        if (expire) begin
            alive_d[BOMB_IDX]    = 1'b0;
            flags_d[BOMB_EN_BIT] = 1'b0;
        end
        if (soft_rst) begin
            x_d     = '0;
            y_d     = '0;
            alive_d = '0;
            flags_d = FLAG_INIT;
        end
    end

    always_comb begin
        rd_word = '0;
        if (is_obj) begin
            case (fld)
                2'd0:    rd_word[COORD_W-1:0] = x_q[oidx];
                2'd1:    rd_word[COORD_W-1:0] = y_q[oidx];
                2'd2:    rd_word[0] = alive_q[oidx];
                default: ;
            endcase
        end else if (is_glb) begin
            case (fld)
                2'd0:    rd_word[FLAG_W-1:0] = flags_q;
                2'd1:    rd_word[1:0] = flags_q[5:4];
                2'd2:    rd_word[CNT_W-1:0] = cnt_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q     <= '0;
            y_q     <= '0;
            alive_q <= '0;
            flags_q <= FLAG_INIT;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            alive_q <= alive_d;
            flags_q <= flags_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en_i;
            if (rd_en_i) rdata_q <= rd_word;
        end
    end

    assign rdata_o    = rdata_q;
    assign rd_valid_o = rd_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bomb_wr && wdata_i[0]) begin
                    state_d = ARMED;
                    cnt_d   = CNT_LOAD;
                end
            end
            default: begin
                if (bomb_wr) begin
                    state_d = wdata_i[0] ? ARMED : IDLE;
                    cnt_d   = wdata_i[0] ? CNT_LOAD : '0;
                end else if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        endcase
        if (soft_rst) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_comb begin
        fuse_busy_o = (state_q == ARMED);
        boom_o      = expire;
    end

    logic unused_bits;
`ifdef OBJ_STATE_SHADOW_EN
    logic [NUM_OBJ-1:0][COORD_W-1:0] sx_q, sy_q;
    logic [NUM_OBJ-1:0]              salive_q;
    logic [FLAG_W-1:0]               sflags_q;

    // Copy next-state so writes and expiries in the sync cycle are captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sx_q     <= '0;
            sy_q     <= '0;
            salive_q <= '0;
            sflags_q <= FLAG_INIT;
        end else if (frame_sync_i || soft_rst) begin
            sx_q     <= x_d;
            sy_q     <= y_d;
            salive_q <= alive_d;
            sflags_q <= flags_d;
        end
    end

    assign disp_x_o     = sx_q;
    assign disp_y_o     = sy_q;
    assign disp_alive_o = salive_q;
    assign disp_flags_o = sflags_q;
    assign unused_bits  = ^wdata_i[31:FLAG_W];
`else
    assign disp_x_o     = x_q;
    assign disp_y_o     = y_q;
    assign disp_alive_o = alive_q;
    assign disp_flags_o = flags_q;
    assign unused_bits  = ^{frame_sync_i, wdata_i[31:FLAG_W]};
`endif
endmodule

// File: tb/tb_obj_state_bank.sv
// Bench for obj_state_bank: directed literal checks plus randomized traffic against a behavioural model.
module tb_obj_state_bank;
    localparam int FUSE = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr = 1'b0, rd = 1'b0, fs = 1'b0;
    logic [4:0]  addr = '0;
    logic [31:0] wd = '0;
    logic [31:0] rdata_o;
    logic        rd_valid_o, boom_o, fuse_busy_o;
    logic [19:0] disp_x_o, disp_y_o;
    logic [3:0]  disp_alive_o;
    logic [9:0]  disp_flags_o;

    obj_state_bank #(.FUSE_CYCLES(FUSE)) dut (
        .clk(clk), .rst(rst), .wr_en_i(wr), .rd_en_i(rd), .addr_i(addr), .wdata_i(wd),
        .rdata_o(rdata_o), .rd_valid_o(rd_valid_o), .frame_sync_i(fs),
        .disp_x_o(disp_x_o), .disp_y_o(disp_y_o), .disp_alive_o(disp_alive_o),
        .disp_flags_o(disp_flags_o), .boom_o(boom_o), .fuse_busy_o(fuse_busy_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    // Behavioural model: plain arrays, fuse tracked as an absolute expiry cycle.
    logic [3:0][4:0] mx = '0, my = '0, sx = '0, sy = '0;
    logic [3:0]      ma = '0, sa = '0;
    logic [9:0]      mf = 10'h030, sf = 10'h030;
    logic            m_armed = 1'b0, m_valid = 1'b0;
    int              m_deadline = 0;
    int              cyc = 0;
    logic [31:0]     m_rdata = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        logic [2:0] i;
        logic [1:0] f;
        i = a[4:2];
        f = a[1:0];
        if (i < 3'd4) begin
            if (f == 2'd0) return {27'd0, mx[i[1:0]]};
            if (f == 2'd1) return {27'd0, my[i[1:0]]};
            if (f == 2'd2) return {31'd0, ma[i[1:0]]};
        end else if (i == 3'd4) begin
            if (f == 2'd0) return {22'd0, mf};
            if (f == 2'd1) return {30'd0, mf[5:4]};
            if (f == 2'd2) return m_armed ? 32'(m_deadline - cyc) : 32'd0;
        end
        return 32'd0;
    endfunction

    function automatic logic model_expiry();
        logic bw, sr;
        bw = wr && addr == 5'd10;
        sr = wr && addr == 5'd19;
        return m_armed && (cyc == m_deadline) && !bw && !sr;
    endfunction

    task automatic model_reset();
        mx = '0; my = '0; ma = '0; mf = 10'h030;
        sx = '0; sy = '0; sa = '0; sf = 10'h030;
        m_armed = 1'b0; m_rdata = '0; m_valid = 1'b0;
    endtask

    task automatic model_step();
        logic [2:0] i;
        logic [1:0] f;
        logic       ex;
        i  = addr[4:2];
        f  = addr[1:0];
        ex = model_expiry();
        m_valid = rd;
        if (rd) m_rdata = model_read(addr);
        if (wr && i < 3'd4) begin
            case (f)
                2'd0: mx[i[1:0]] = wd[4:0];
                2'd1: my[i[1:0]] = wd[4:0];
                2'd2: ma[i[1:0]] = wd[0];
                default: begin mx[i[1:0]] = mx[0]; my[i[1:0]] = my[0]; end
            endcase
        end else if (wr && i == 3'd4) begin
            if (f == 2'd0) mf = wd[9:0];
            if (f == 2'd1) mf[5:4] = wd[1:0];
        end
        if (ex) begin ma[2] = 1'b0; mf[9] = 1'b0; m_armed = 1'b0; end
        if (wr && addr == 5'd10) begin m_armed = wd[0]; m_deadline = cyc + FUSE; end
        if (wr && addr == 5'd19) begin
            mx = '0; my = '0; ma = '0; mf = 10'h030; m_armed = 1'b0;
        end
        if (fs || (wr && addr == 5'd19)) begin sx = mx; sy = my; sa = ma; sf = mf; end
        cyc++;
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) model_reset(); else model_step();
    end

    // Per-cycle comparison of every output against the model.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("rd_valid", {31'd0, rd_valid_o}, {31'd0, m_valid});
            chk("rdata", rdata_o, m_rdata);
            chk("fuse_busy", {31'd0, fuse_busy_o}, {31'd0, m_armed});
            chk("boom", {31'd0, boom_o}, {31'd0, model_expiry() && !rst});
`ifdef OBJ_STATE_SHADOW_EN
            chk("disp_x", {12'd0, disp_x_o}, {12'd0, sx});
            chk("disp_y", {12'd0, disp_y_o}, {12'd0, sy});
            chk("disp_alive", {28'd0, disp_alive_o}, {28'd0, sa});
            chk("disp_flags", {22'd0, disp_flags_o}, {22'd0, sf});
`else
            chk("disp_x", {12'd0, disp_x_o}, {12'd0, mx});
            chk("disp_y", {12'd0, disp_y_o}, {12'd0, my});
            chk("disp_alive", {28'd0, disp_alive_o}, {28'd0, ma});
            chk("disp_flags", {22'd0, disp_flags_o}, {22'd0, mf});
`endif
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    logic s_boom, s_busy;

    task automatic do_cycle(input logic w, input logic r, input logic [4:0] a,
                            input logic [31:0] d, input logic f);
        wr = w; rd = r; addr = a; wd = d; fs = f;
        @(negedge clk);
        s_boom = boom_o;
        s_busy = fuse_busy_o;
        @(posedge clk);
        #1;
        wr = 1'b0; rd = 1'b0; addr = '0; wd = '0; fs = 1'b0;
    endtask

    task automatic run_fuse(input int act_k, input logic act_val,
                            output int boom_k, output int busy_n, output int booms);
        do_cycle(1'b1, 1'b0, 5'd10, 32'd1, 1'b0);
        boom_k = 0; busy_n = 0; booms = 0;
        for (int k = 1; k <= 16; k++) begin
            if (k == act_k) do_cycle(1'b1, 1'b0, 5'd10, {31'd0, act_val}, 1'b0);
            else            do_cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
            if (s_boom) begin booms++; boom_k = k; end
            if (s_busy) busy_n++;
        end
    endtask

    int bk, bn, bc;
    logic [4:0] ra;

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;

        do_cycle(1'b0, 1'b1, 5'd16, 32'd0, 1'b0);
        chk("lit_reset_flags", rdata_o, 32'h030);
        chk("lit_reset_valid", {31'd0, rd_valid_o}, 32'd1);
        chk("lit_reset_disp_x", {12'd0, disp_x_o}, 32'd0);
        chk("lit_reset_disp_flags", {22'd0, disp_flags_o}, 32'h030);

        do_cycle(1'b1, 1'b0, 5'd0, 32'd3, 1'b0);
        do_cycle(1'b1, 1'b0, 5'd1, 32'd7, 1'b0);
        do_cycle(1'b1, 1'b0, 5'd11, 32'd0, 1'b0);
        do_cycle(1'b0, 1'b1, 5'd8, 32'd0, 1'b0);
        chk("lit_copy_x", rdata_o, 32'd3);
        do_cycle(1'b0, 1'b1, 5'd9, 32'd0, 1'b0);
        chk("lit_copy_y", rdata_o, 32'd7);
`ifdef OBJ_STATE_SHADOW_EN
        chk("lit_disp_x2_pre_sync", {27'd0, disp_x_o[14:10]}, 32'd0);
`else
        chk("lit_disp_x2_pre_sync", {27'd0, disp_x_o[14:10]}, 32'd3);
`endif
        do_cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
        chk("lit_disp_x2_post_sync", {27'd0, disp_x_o[14:10]}, 32'd3);

        do_cycle(1'b1, 1'b0, 5'd16, 32'h230, 1'b0);
        run_fuse(0, 1'b0, bk, bn, bc);
        chk("lit_fuse_boom_cycle", 32'(bk), 32'd8);
        chk("lit_fuse_busy_cycles", 32'(bn), 32'd8);
        chk("lit_fuse_boom_count", 32'(bc), 32'd1);
        do_cycle(1'b0, 1'b1, 5'd10, 32'd0, 1'b0);
        chk("lit_fuse_alive_cleared", rdata_o, 32'd0);
        do_cycle(1'b0, 1'b1, 5'd16, 32'd0, 1'b0);
        chk("lit_fuse_bomb_en_cleared", rdata_o, 32'h030);

        run_fuse(5, 1'b1, bk, bn, bc);
        chk("lit_restart_boom_cycle", 32'(bk), 32'd13);
        chk("lit_restart_boom_count", 32'(bc), 32'd1);
        run_fuse(5, 1'b0, bk, bn, bc);
        chk("lit_cancel_boom_count", 32'(bc), 32'd0);
        chk("lit_cancel_busy_cycles", 32'(bn), 32'd5);

        do_cycle(1'b0, 1'b1, 5'd0, 32'd0, 1'b0);
        do_cycle(1'b0, 1'b1, 5'd20, 32'd0, 1'b0);
        chk("lit_idx5_rdata", rdata_o, 32'd0);
        chk("lit_idx5_valid", {31'd0, rd_valid_o}, 32'd1);
        do_cycle(1'b1, 1'b0, 5'd20, 32'h1f, 1'b0);
        do_cycle(1'b0, 1'b1, 5'd0, 32'd0, 1'b0);
        chk("lit_idx5_write_ignored", rdata_o, 32'd3);

        do_cycle(1'b1, 1'b0, 5'd4, 32'd9, 1'b0);
        do_cycle(1'b1, 1'b1, 5'd4, 32'd4, 1'b0);
        chk("lit_rw_old_value", rdata_o, 32'd9);
        do_cycle(1'b0, 1'b1, 5'd4, 32'd0, 1'b0);
        chk("lit_rw_new_value", rdata_o, 32'd4);

        do_cycle(1'b1, 1'b0, 5'd10, 32'd1, 1'b0);
        repeat (3) do_cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        do_cycle(1'b1, 1'b0, 5'd19, 32'd0, 1'b0);
        bc = 0; bn = 0;
        for (int k = 0; k < 12; k++) begin
            do_cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
            if (s_boom) bc++;
            if (s_busy) bn++;
        end
        chk("lit_soft_rst_no_boom", 32'(bc), 32'd0);
        chk("lit_soft_rst_busy", 32'(bn), 32'd0);
        do_cycle(1'b0, 1'b1, 5'd0, 32'd0, 1'b0);
        chk("lit_soft_rst_x0", rdata_o, 32'd0);
        do_cycle(1'b0, 1'b1, 5'd16, 32'd0, 1'b0);
        chk("lit_soft_rst_flags", rdata_o, 32'h030);

        do_cycle(1'b1, 1'b0, 5'd0, 32'd5, 1'b0);
        do_cycle(1'b1, 1'b0, 5'd10, 32'd1, 1'b0);
        repeat (3) do_cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("lit_rst_busy", {31'd0, fuse_busy_o}, 32'd0);
        chk("lit_rst_valid", {31'd0, rd_valid_o}, 32'd0);
        chk("lit_rst_disp_x", {12'd0, disp_x_o}, 32'd0);
        bc = 0;
        for (int k = 0; k < 12; k++) begin
            do_cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
            if (s_boom) bc++;
        end
        chk("lit_rst_no_boom", 32'(bc), 32'd0);

        for (int n = 0; n < 3000; n++) begin
            ra = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) ra = 5'd10;
            if (ra == 5'd19 && $urandom_range(0, 19) != 0) ra = 5'd18;
            do_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, ra, $urandom,
                     $urandom_range(0, 7) == 0);
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
